i2c_target_rx: RTL

- Write-only I2C target receiver. Sits downstream of the team's I2C master driver and consumes its open-drain SDA/SCL lines.
- Oversamples SCL/SDA on the system clock and detects START and STOP conditions.
- Decodes the 7-bit address and R/W bit, drives ACK/NACK on SDA, and hands each received data byte to local logic with a ready/valid handshake.

---
 rtl/i2c_target_rx_if.sv | 23 ++
 rtl/i2c_target_rx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx_if.sv
// Bus-side and local-handshake signals of the I2C write-only target receiver.
// The slave modport is the receiver's view; master is the driving environment.
interface i2c_target_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       overflow;
    logic [2:0] state;

    modport slave (
        input  scl_in, sda_in, rx_ready,
        output sda_oe, rx_data, rx_valid, busy, overflow, state
    );

    modport master (
        output scl_in, sda_in, rx_ready,
        input  sda_oe, rx_data, rx_valid, busy, overflow, state
    );
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target receiver: oversamples SCL/SDA, detects START/STOP,
// matches the 7-bit address, ACKs/NACKs on SDA and delivers data bytes
// through a one-cycle rx_valid pulse gated by rx_ready.
module i2c_target_rx #(
    parameter logic [6:0] DEV_ADDR    = 7'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    i2c_target_rx_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        DATA   = 3'd3,
        ACK_D  = 3'd4,
        IGNORE = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_d_q, sda_d_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t      state_q, state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [7:0]  shift_q, shift_n;
    logic [7:0]  data_q, data_n;
    logic        vld_q, vld_n;
    logic        oe_q, oe_n;
    logic        busy_q, busy_n;
    logic        ovf_q, ovf_n;

    // Bring both bus lines into the clock domain, plus one delay flop for edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_d_q    <= scl_sync_q[SYNC_STAGES-1];
            sda_d_q    <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_d_q;
    assign scl_fall  = ~scl_s &  scl_d_q;
    // SCL must be high on both samples so an SDA move at an SCL edge is not a bus condition.
    assign start_det =  scl_s &  scl_d_q &  sda_d_q & ~sda_s;
    assign stop_det  =  scl_s &  scl_d_q & ~sda_d_q &  sda_s;

    // Register the FSM state and all protocol outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            vld_q   <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            shift_q <= shift_n;
            data_q  <= data_n;
            vld_q   <= vld_n;
            oe_q    <= oe_n;
            busy_q  <= busy_n;
            ovf_q   <= ovf_n;
        end
    end

    // Next-state and output decode; STOP outranks START, which outranks SCL edges.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        shift_n = shift_q;
        data_n  = data_q;
        vld_n   = 1'b0;
        oe_n    = oe_q;
        busy_n  = busy_q;
        ovf_n   = ovf_q;

        if (stop_det && state_q != IDLE) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_det) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            ovf_n   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_n = 4'd0;
                    oe_n  = 1'b0;
                end
                ADDR, DATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_n = {shift_q[6:0], sda_s};
                        cnt_n   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                                oe_n    = 1'b1;
                                busy_n  = 1'b1;
                                state_n = ACK_A;
                            end else begin
                                oe_n    = 1'b0;
                                state_n = IGNORE;
                            end
                        end else begin
                            if (bus.rx_ready) begin
                                data_n = shift_q;
                                vld_n  = 1'b1;
                                oe_n   = 1'b1;
                            end else begin
                                ovf_n  = 1'b1;
                                oe_n   = 1'b0;
                            end
                            state_n = ACK_D;
                        end
                    end
                end
                ACK_A, ACK_D: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = DATA;
                    end
                end
                IGNORE: begin
                    oe_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = oe_q;
    assign bus.rx_data  = data_q;
    assign bus.rx_valid = vld_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
    assign bus.state    = state_q;

endmodule
